traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/phase_timer.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 142 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: phase enumeration, lamp codes
// and the fixed phase rotation.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_1  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_2  = 3'd5,
    NIGHT  = 3'd6
  } state_t;

  // Lamp encoding: bit2 red, bit1 yellow, bit0 green.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic state_t next_phase(input state_t s);
    case (s)
      MAIN_G:  next_phase = MAIN_Y;
      MAIN_Y:  next_phase = RED_1;
      RED_1:   next_phase = SIDE_G;
      SIDE_G:  next_phase = SIDE_Y;
      SIDE_Y:  next_phase = RED_2;
      default: next_phase = MAIN_G;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase countdown register: load has priority over tick; never counts below zero.
module phase_timer #(
  parameter int              W         = 7,
  parameter logic [W-1:0]    RST_VALUE = '0
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_count <= RST_VALUE;
    end else if (load) begin
      r_count <= load_value;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with pedestrian green cut and night
// flashing-yellow mode; all outputs registered.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int T_MAIN_GREEN = 30,
  parameter int T_SIDE_GREEN = 20,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int T_PED_CUT    = 5
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic [6:0] countdown,
  output logic       ped_pending,
  output state_t     o_dbg_state
);

  localparam logic [6:0] D_MG = 7'(T_MAIN_GREEN);
  localparam logic [6:0] D_SG = 7'(T_SIDE_GREEN);
  localparam logic [6:0] D_Y  = 7'(T_YELLOW);
  localparam logic [6:0] D_AR = 7'(T_ALL_RED);
  localparam logic [6:0] D_PC = 7'(T_PED_CUT);

  function automatic logic [6:0] duration(input state_t s);
    case (s)
      MAIN_G:          duration = D_MG;
      SIDE_G:          duration = D_SG;
      MAIN_Y, SIDE_Y:  duration = D_Y;
      RED_1, RED_2:    duration = D_AR;
      default:         duration = 7'd0;
    endcase
  endfunction

  state_t     r_state;
  logic       r_flash;
  logic       r_ped;
  logic [2:0] r_main_lamp;
  logic [2:0] r_side_lamp;

  state_t     w_next_state;
  logic       w_next_flash;
  logic       w_load;
  logic [6:0] w_load_value;
  logic       w_tick;
  logic [6:0] w_count;
  logic [2:0] w_main_lamp;
  logic [2:0] w_side_lamp;

  phase_timer #(.W(7), .RST_VALUE(D_AR)) u_timer (
    .clkin      (clkin),
    .rst        (rst),
    .load       (w_load),
    .load_value (w_load_value),
    .tick       (w_tick),
    .count      (w_count)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state     <= RED_2;
      r_flash     <= 1'b0;
      r_ped       <= 1'b0;
      r_main_lamp <= LAMP_RED;
      r_side_lamp <= LAMP_RED;
    end else begin
      r_state     <= w_next_state;
      r_flash     <= w_next_flash;
      r_main_lamp <= w_main_lamp;
      r_side_lamp <= w_side_lamp;
      // A fresh request in the same cycle as side-green entry stays latched.
      if (ped_req) begin
        r_ped <= 1'b1;
      end else if ((w_next_state == SIDE_G) && (r_state != SIDE_G)) begin
        r_ped <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_flash = 1'b0;
    w_load       = 1'b0;
    w_load_value = 7'd0;
    w_tick       = 1'b0;
    if (r_state == NIGHT) begin
      w_next_flash = r_flash;
      if (tick_en) begin
        if (night_mode) begin
          w_next_flash = ~r_flash;
        end else begin
          w_next_state = RED_2;
          w_load       = 1'b1;
          w_load_value = D_AR;
        end
      end
    end else if (tick_en) begin
      if (w_count == 7'd1) begin
        w_next_state = next_phase(r_state);
        if (night_mode && ((r_state == RED_1) || (r_state == RED_2))) begin
          w_next_state = NIGHT;
        end
        w_load       = 1'b1;
        w_load_value = duration(w_next_state);
      end else if ((r_state == MAIN_G) && r_ped && (w_count > D_PC)) begin
        w_load       = 1'b1;
        w_load_value = D_PC;
      end else begin
        w_tick = 1'b1;
      end
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    w_main_lamp = LAMP_RED;
    w_side_lamp = LAMP_RED;
    case (w_next_state)
      MAIN_G: w_main_lamp = LAMP_GRN;
      MAIN_Y: w_main_lamp = LAMP_YEL;
      SIDE_G: w_side_lamp = LAMP_GRN;
      SIDE_Y: w_side_lamp = LAMP_YEL;
      NIGHT: begin
        w_main_lamp = w_next_flash ? LAMP_YEL : LAMP_OFF;
        w_side_lamp = w_next_flash ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign main_lamp   = r_main_lamp;
  assign side_lamp   = r_side_lamp;
  assign countdown   = w_count;
  assign ped_pending = r_ped;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: a vector table for the opening
// sequence, then hand sequences for full cycle, late ped, night and reset.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic [6:0] countdown;
  logic       ped_pending;
  state_t     o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  traffic_light_ctrl dut (
    .clkin       (clkin),
    .rst         (rst),
    .tick_en     (tick_en),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .main_lamp   (main_lamp),
    .side_lamp   (side_lamp),
    .countdown   (countdown),
    .ped_pending (ped_pending),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  typedef struct {
    logic       tick;
    logic       ped;
    logic       night;
    state_t     st;
    logic [6:0] cnt;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       pp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [16:0] pk(input state_t st, input logic [6:0] cnt,
                                     input logic [2:0] ml, input logic [2:0] sl,
                                     input logic pp);
    pk = {st, cnt, ml, sl, pp};
  endfunction

  task automatic add(input logic t, input logic p, input logic n, input state_t st,
                     input logic [6:0] cnt, input logic [2:0] ml, input logic [2:0] sl,
                     input logic pp);
    vec_t v;
    v.tick = t; v.ped = p; v.night = n; v.st = st;
    v.cnt = cnt; v.ml = ml; v.sl = sl; v.pp = pp;
    vq.push_back(v);
  endtask

  // driver: inputs applied 1ns after a rising edge, held through the next one
  task automatic step(input logic t, input logic p);
    tick_en = t;
    ped_req = p;
    @(posedge clkin);
    #1;
    tick_en = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {o_dbg_state, countdown, main_lamp, side_lamp, ped_pending};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%0d main=%b side=%b ped=%b, want st=%0d cnt=%0d main=%b side=%b ped=%b",
               name, act[16:14], act[13:7], act[6:4], act[3:1], act[0],
               exp[16:14], exp[13:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic chk(input string name, input state_t st, input logic [6:0] cnt,
                     input logic [2:0] ml, input logic [2:0] sl, input logic pp);
    exp_q.push_back(pk(st, cnt, ml, sl, pp));
    check(name, exp_q.pop_front());
  endtask

  initial begin
    // opening sequence: reset hold, first green, ped cut with same-cycle tick
    add(0, 0, 0, RED_2,  7'd2,  LAMP_RED, LAMP_RED, 0);
    add(1, 0, 0, RED_2,  7'd1,  LAMP_RED, LAMP_RED, 0);
    add(0, 0, 0, RED_2,  7'd1,  LAMP_RED, LAMP_RED, 0);
    add(1, 0, 0, MAIN_G, 7'd30, LAMP_GRN, LAMP_RED, 0);
    add(1, 0, 0, MAIN_G, 7'd29, LAMP_GRN, LAMP_RED, 0);
    add(1, 1, 0, MAIN_G, 7'd28, LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_G, 7'd5,  LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_G, 7'd4,  LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_G, 7'd3,  LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_G, 7'd2,  LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_G, 7'd1,  LAMP_GRN, LAMP_RED, 1);
    add(1, 0, 0, MAIN_Y, 7'd3,  LAMP_YEL, LAMP_RED, 1);
    add(1, 0, 0, MAIN_Y, 7'd2,  LAMP_YEL, LAMP_RED, 1);
    add(1, 0, 0, MAIN_Y, 7'd1,  LAMP_YEL, LAMP_RED, 1);
    add(1, 0, 0, RED_1,  7'd2,  LAMP_RED, LAMP_RED, 1);
    add(1, 0, 0, RED_1,  7'd1,  LAMP_RED, LAMP_RED, 1);
    add(1, 0, 0, SIDE_G, 7'd20, LAMP_RED, LAMP_GRN, 0);

    repeat (3) @(posedge clkin);
    #1;
    chk("reset_state", RED_2, 7'd2, LAMP_RED, LAMP_RED, 0);
    rst = 1'b0;

    foreach (vq[i]) exp_q.push_back(pk(vq[i].st, vq[i].cnt, vq[i].ml, vq[i].sl, vq[i].pp));
    foreach (vq[i]) begin
      night_mode = vq[i].night;
      step(vq[i].tick, vq[i].ped);
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // full cycle from side green back to main green
    ticks(20); chk("side_yellow", SIDE_Y, 7'd3, LAMP_RED, LAMP_YEL, 0);
    ticks(3);  chk("red2",        RED_2,  7'd2, LAMP_RED, LAMP_RED, 0);
    ticks(2);  chk("main_green",  MAIN_G, 7'd30, LAMP_GRN, LAMP_RED, 0);

    // late pedestrian request: no cut
    ticks(26);       chk("main_g_4",    MAIN_G, 7'd4, LAMP_GRN, LAMP_RED, 0);
    step(1'b0, 1'b1); chk("late_ped",   MAIN_G, 7'd4, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("late_3",      MAIN_G, 7'd3, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("late_2",      MAIN_G, 7'd2, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("late_1",      MAIN_G, 7'd1, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("late_main_y", MAIN_Y, 7'd3, LAMP_YEL, LAMP_RED, 1);
    ticks(5);        chk("late_side_g", SIDE_G, 7'd20, LAMP_RED, LAMP_GRN, 0);

    // night mode requested during side green, exit via RED_2
    night_mode = 1'b1;
    ticks(20);       chk("n_side_y",   SIDE_Y, 7'd3, LAMP_RED, LAMP_YEL, 0);
    ticks(3);        chk("n_red2",     RED_2,  7'd2, LAMP_RED, LAMP_RED, 0);
    ticks(2);        chk("n_enter",    NIGHT,  7'd0, LAMP_OFF, LAMP_OFF, 0);
    ticks(1);        chk("n_flash_on", NIGHT,  7'd0, LAMP_YEL, LAMP_YEL, 0);
    step(1'b0, 1'b1); chk("n_hold_ped", NIGHT, 7'd0, LAMP_YEL, LAMP_YEL, 1);
    ticks(1);        chk("n_flash_off", NIGHT, 7'd0, LAMP_OFF, LAMP_OFF, 1);
    night_mode = 1'b0;
    ticks(1);        chk("n_exit",     RED_2,  7'd2, LAMP_RED, LAMP_RED, 1);
    ticks(2);        chk("n_main_g",   MAIN_G, 7'd30, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("n_cut",      MAIN_G, 7'd5, LAMP_GRN, LAMP_RED, 1);

    // night mode entered from RED_1
    night_mode = 1'b1;
    ticks(5);        chk("r1_main_y",  MAIN_Y, 7'd3, LAMP_YEL, LAMP_RED, 1);
    ticks(3);        chk("r1_red1",    RED_1,  7'd2, LAMP_RED, LAMP_RED, 1);
    ticks(2);        chk("r1_night",   NIGHT,  7'd0, LAMP_OFF, LAMP_OFF, 1);
    night_mode = 1'b0;
    ticks(1);        chk("r1_exit",    RED_2,  7'd2, LAMP_RED, LAMP_RED, 1);
    ticks(2);        chk("r1_main_g",  MAIN_G, 7'd30, LAMP_GRN, LAMP_RED, 1);
    ticks(1);        chk("r1_cut",     MAIN_G, 7'd5, LAMP_GRN, LAMP_RED, 1);

    // asynchronous reset mid side-yellow
    ticks(5);        chk("rs_main_y",  MAIN_Y, 7'd3, LAMP_YEL, LAMP_RED, 1);
    ticks(5);        chk("rs_side_g",  SIDE_G, 7'd20, LAMP_RED, LAMP_GRN, 0);
    step(1'b0, 1'b1); chk("rs_ped",    SIDE_G, 7'd20, LAMP_RED, LAMP_GRN, 1);
    ticks(21);       chk("rs_side_y",  SIDE_Y, 7'd2, LAMP_RED, LAMP_YEL, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", RED_2, 7'd2, LAMP_RED, LAMP_RED, 0);
    @(posedge clkin);
    #1;
    rst = 1'b0;
    ticks(1);        chk("post_rst",   RED_2, 7'd1, LAMP_RED, LAMP_RED, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
